// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU instruction sequencer.
package npu_pkg;

    localparam int INST_W  = 128;
    localparam int PC_W    = 8;
    localparam int FLAG_AW = 9;

    localparam logic [7:0] DONE_TOKEN = 8'h01;
    localparam logic [7:0] HALT_OP    = 8'hFF;

    localparam int OPC_HI = 127;
    localparam int OPC_LO = 120;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POLL,
        S_CHK,
        S_FETCH,
        S_LOAD,
        S_ISSUE,
        S_EXEC,
        S_POST
    } seq_state_t;

    function automatic logic is_halt_op(input logic [INST_W-1:0] inst);
        return inst[OPC_HI:OPC_LO] == HALT_OP;
    endfunction

endpackage

// File: rtl/npu_inst_sequencer.sv
// Fetch/dispatch controller: walks the instruction ring shared with the HPS,
// hands each valid slot to the execute engine and posts a completion token.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | stopped; waits for enable with run_armed set
// S_POLL  | read inst_valid[pc]
// S_CHK   | flag data back; valid -> fetch, empty -> re-poll or stop
// S_FETCH | read inst_sram[pc]
// S_LOAD  | latch instruction; HALT skips the engine
// S_ISSUE | offer instruction to engine until accepted
// S_EXEC  | wait for engine completion pulse
// S_POST  | write done token, clear flag, advance pc
module npu_inst_sequencer
    import npu_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic [FLAG_AW-1:0] ivld_address,
    output logic               ivld_chipselect,
    output logic               ivld_write,
    output logic [7:0]         ivld_writedata,
    input  logic [7:0]         ivld_readdata,
    output logic [PC_W-1:0]    isram_address,
    output logic               isram_chipselect,
    input  logic [INST_W-1:0]  isram_readdata,
    output logic [FLAG_AW-1:0] done_address,
    output logic               done_chipselect,
    output logic               done_write,
    output logic [7:0]         done_writedata,
    output logic               exe_valid,
    output logic [INST_W-1:0]  exe_inst,
    input  logic               exe_ready,
    input  logic               exe_done,
    output logic [PC_W-1:0]    pc,
    output logic               busy
);

    seq_state_t state;
    seq_state_t state_nxt;
    logic       run_armed;
    logic       halt_q;

    // Addresses follow the registered pc directly; pc only moves at the end of S_POST.
    assign ivld_address   = {1'b0, pc};
    assign isram_address  = pc;
    assign done_address   = {1'b0, pc};
    assign ivld_writedata = 8'h00;

    // Next-state decision; strobes are then registered from it so they line up with the state.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (enable && run_armed) state_nxt = S_POLL;
            S_POLL:  state_nxt = S_CHK;
            S_CHK: begin
                if (ivld_readdata != 8'h00) state_nxt = S_FETCH;
                else if (!enable)           state_nxt = S_IDLE;
                else                        state_nxt = S_POLL;
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD:  state_nxt = is_halt_op(isram_readdata) ? S_POST : S_ISSUE;
            S_ISSUE: if (exe_ready) state_nxt = exe_done ? S_POST : S_EXEC;
            S_EXEC:  if (exe_done)  state_nxt = S_POST;
            S_POST:  state_nxt = (halt_q || !enable) ? S_IDLE : S_POLL;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register, registered strobes, instruction latch and pc/run_armed bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= S_IDLE;
            run_armed        <= 1'b1;
            halt_q           <= 1'b0;
            pc               <= '0;
            busy             <= 1'b0;
            ivld_chipselect  <= 1'b0;
            ivld_write       <= 1'b0;
            isram_chipselect <= 1'b0;
            done_chipselect  <= 1'b0;
            done_write       <= 1'b0;
            done_writedata   <= 8'h00;
            exe_valid        <= 1'b0;
            exe_inst         <= '0;
        end else begin
            state            <= state_nxt;
            busy             <= (state_nxt != S_IDLE);
            ivld_chipselect  <= (state_nxt == S_POLL) || (state_nxt == S_POST);
            ivld_write       <= (state_nxt == S_POST);
            isram_chipselect <= (state_nxt == S_FETCH);
            done_chipselect  <= (state_nxt == S_POST);
            done_write       <= (state_nxt == S_POST);
            done_writedata   <= DONE_TOKEN;
            exe_valid        <= (state_nxt == S_ISSUE);

            if (state == S_IDLE && !enable) run_armed <= 1'b1;

            if (state == S_LOAD) begin
                exe_inst <= isram_readdata;
                halt_q   <= is_halt_op(isram_readdata);
            end

            // HALT leaves the sequencer disarmed until the HPS drops enable.
            if (state == S_POST) begin
                pc <= pc + 1'b1;
                if (halt_q) run_armed <= 1'b0;
            end
        end
    end

endmodule
